result_read_controller: RTL and testbench
=========================================

# result_read_controller

Memory-mapped read responder for the CNN accelerator slave: the read-side counterpart of the store controller that fills pixel/weight/bias memories from CPU writes. It accepts single-beat CPU read requests, decodes the address, and returns one of three things. For the result window it returns the next layer-1 output word from the local result memory, using an auto-incrementing counter. For the image-set and interrupt addresses it returns the current register value. It sits between the bus slave port and the result SRAM, which has 1-cycle read latency.

## Interface
- LAYER1_RESULT_NUM, 16'd8192, number of 16-bit result words in layer 1 (32x32x8)
- RESULT_ADDRESS, 32'hd000_0000, result read window
- IMAGE_SET_REGISTER_ADDRESS, 32'hd111_0000, image set register
- INTERRUPT_REGISTER_ADDRESS, 32'hd222_0000, interrupt register
- clk  input  1  clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- araddr  input  32  read address, valid with arvalid
- arvalid  input  1  read request
- arready  output  1  request accepted when arvalid&&arready
- rdata  output  32  read data, valid with rvalid
- rvalid  output  1  read data valid
- rready  input  1  data consumed when rvalid&&rready
- layer1_result_store_done  input  1  level: result memory fully written by the compute engine
- image_set_register_data_output  input  2  current image set register value
- interrupr_register_data_output  input  1  current interrupt register value
- read_result_mem  output  1  result SRAM read strobe
- result_mem_addr  output  16  result SRAM address
- result_mem_data  input  16  SRAM read data, valid the cycle after the strobe
- layer1_result_read_done  output  1  one-cycle pulse after the last result word is accepted

## Operation
- FSM states: IDLE, MEM_WAIT, RESP. Reset state is IDLE.
- IDLE:
  - arready=1.
  - On arvalid, decode araddr with a full 32-bit compare.
- Decode outcomes:
  - araddr==RESULT_ADDRESS and layer1_result_store_done=1:
    - Assert read_result_mem=1 combinationally, with result_mem_addr=count.
    - Count increments at the clock edge.
    - Next state MEM_WAIT.
  - araddr==RESULT_ADDRESS and store not done:
    - No SRAM access; count is unchanged.
    - Capture rdata=0. Next state RESP.
  - araddr==IMAGE_SET_REGISTER_ADDRESS: capture rdata={30'd0, image_set_register_data_output}. Next state RESP.
  - araddr==INTERRUPT_REGISTER_ADDRESS: capture rdata={31'd0, interrupr_register_data_output}. Next state RESP.
  - Any other address: capture rdata=0. Next state RESP.
- MEM_WAIT:
  - arready=0, read_result_mem=0.
  - Capture rdata={{16{result_mem_data[15]}}, result_mem_data}, i.e. sign-extended Q-format.
  - Next state RESP.
- RESP:
  - rvalid=1, rdata held stable.
  - Stay in RESP until rready is seen; then go to IDLE.
- Counter:
  - 16-bit.
  - When the last word is accepted (count==LAYER1_RESULT_NUM-1), count wraps to 0 and layer1_result_read_done pulses high for the next cycle.
- When read_result_mem=0, result_mem_addr=0.

## Timing
- Reset values: arready=1 (IDLE), rvalid=0, rdata=0, read_result_mem=0, result_mem_addr=0, layer1_result_read_done=0, count=0.
- Result read:
  - Handshake in cycle T; SRAM strobe in T.
  - Data captured at the end of T+1.
  - rvalid=1 from T+2.
- Register/unmapped/not-ready read:
  - Handshake in T.
  - rvalid=1 from T+1.
- RESP exit: rvalid&&rready in cycle X gives IDLE (arready=1) at X+1.
- Throughput: one result read per 3 cycles, one register read per 2 cycles.
- Only one outstanding request; arready=0 outside IDLE.
- rdata must not change while rvalid=1 and rready=0.
- rst asserted mid-transaction: everything returns to reset values immediately. Any in-flight response is dropped and the counter restarts at 0.
- layer1_result_store_done falling mid-sequence does not clear count; only wrap or rst clears it.

## Test plan
- Reset: assert rst mid-RESP -> rvalid=0, arready=1, count=0 on the same cycle as reset assertion.
- Register read: image_set_register_data_output=2'b10, read 32'hd111_0000 with rready=1 -> rdata=32'h0000_0002 with rvalid at T+1. Read 32'hd222_0000 with interrupt=1 -> 32'h0000_0001.
- Sequential results: store_done=1, SRAM preloaded with word i = i-4096 (mod 2^16). 8192 reads of 32'hd000_0000 -> addresses 0..8191 strobed in order; rdata[0]=32'hFFFF_F000; layer1_result_read_done pulses once after read 8191; the next read uses address 0.
- Not ready: store_done=0, read 32'hd000_0000 -> rdata=0, no read_result_mem strobe. Later, with store_done=1, the first read uses address 0.
- Backpressure: hold rready=0 for 5 cycles during a result response -> rvalid stays 1, rdata stays constant, arready stays 0, count advances exactly once.
- Unmapped: read 32'hd000_0004 -> rdata=0, no SRAM strobe, count unchanged.

Source files
------------

// File: rtl/result_read_controller.sv
// Memory-mapped read responder for the CNN accelerator slave: streams layer-1
// results from the result SRAM through an auto-incrementing window and exposes two status registers.
module result_read_controller #(
    parameter logic [15:0] LAYER1_RESULT_NUM          = 16'd8192,
    parameter logic [31:0] RESULT_ADDRESS             = 32'hd000_0000,
    parameter logic [31:0] IMAGE_SET_REGISTER_ADDRESS = 32'hd111_0000,
    parameter logic [31:0] INTERRUPT_REGISTER_ADDRESS = 32'hd222_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    input  logic        layer1_result_store_done,
    input  logic [1:0]  image_set_register_data_output,
    input  logic        interrupr_register_data_output,
    output logic        read_result_mem,
    output logic [15:0] result_mem_addr,
    input  logic [15:0] result_mem_data,
    output logic        layer1_result_read_done
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

    localparam logic [15:0] LAST_IDX = LAYER1_RESULT_NUM - 16'd1;

    state_t      state_q;
    logic [15:0] count_q;
    logic [31:0] rdata_q;
    logic        arready_q;
    logic        rvalid_q;
    logic        done_q;

    logic hit_result;
    logic hit_image;
    logic hit_intr;
    logic mem_rd;

    assign hit_result = (araddr == RESULT_ADDRESS);
    assign hit_image  = (araddr == IMAGE_SET_REGISTER_ADDRESS);
    assign hit_intr   = (araddr == INTERRUPT_REGISTER_ADDRESS);

    // SRAM strobe fires in the handshake cycle so data lands one cycle later.
    assign mem_rd = (state_q == IDLE) && arvalid && hit_result && layer1_result_store_done;

    assign read_result_mem         = mem_rd;
    assign result_mem_addr         = mem_rd ? count_q : 16'd0;
    assign arready                 = arready_q;
    assign rvalid                  = rvalid_q;
    assign rdata                   = rdata_q;
    assign layer1_result_read_done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 16'd0;
            rdata_q   <= 32'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (mem_rd) begin
                if (count_q == LAST_IDX) begin
                    count_q <= 16'd0;
                    done_q  <= 1'b1;
                end else begin
                    count_q <= count_q + 16'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (arvalid) begin
                        arready_q <= 1'b0;
                        if (mem_rd) begin
                            state_q <= MEM_WAIT;
                        end else begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            // Result window before the store completes reads as zero.
                            if (hit_image)
                                rdata_q <= {30'd0, image_set_register_data_output};
                            else if (hit_intr)
                                rdata_q <= {31'd0, interrupr_register_data_output};
                            else
                                rdata_q <= 32'd0;
                        end
                    end
                end
                MEM_WAIT: begin
                    rdata_q  <= {{16{result_mem_data[15]}}, result_mem_data};
                    rvalid_q <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_read_controller.sv
// Directed bench for result_read_controller with a behavioural 1-cycle result SRAM.
module tb_result_read_controller;

    localparam logic [31:0] RES_A = 32'hd000_0000;
    localparam logic [31:0] IMG_A = 32'hd111_0000;
    localparam logic [31:0] INT_A = 32'hd222_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        store_done;
    logic [1:0]  img_reg;
    logic        int_reg;
    logic        read_result_mem;
    logic [15:0] result_mem_addr;
    logic [15:0] result_mem_data = 16'd0;
    logic        read_done;

    int checks   = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int done_cnt   = 0;
    logic [15:0] last_addr = 16'hxxxx;

    result_read_controller dut (
        .clk                            (clk),
        .rst                            (rst),
        .araddr                         (araddr),
        .arvalid                        (arvalid),
        .arready                        (arready),
        .rdata                          (rdata),
        .rvalid                         (rvalid),
        .rready                         (rready),
        .layer1_result_store_done       (store_done),
        .image_set_register_data_output (img_reg),
        .interrupr_register_data_output (int_reg),
        .read_result_mem                (read_result_mem),
        .result_mem_addr                (result_mem_addr),
        .result_mem_data                (result_mem_data),
        .layer1_result_read_done        (read_done)
    );

    always #5 clk = ~clk;

    // SRAM preloaded with word i = i - 4096 (mod 2^16), 1-cycle read latency.
    always @(posedge clk) begin
        if (read_result_mem) begin
            result_mem_data <= result_mem_addr - 16'd4096;
            strobe_cnt      <= strobe_cnt + 1;
            last_addr       <= result_mem_addr;
        end
        if (read_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One read with rready held by the caller; lat counts edges after the handshake until rvalid.
    task automatic rd(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        d = rdata;
        if (rready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] d0;
        logic [15:0] v;
        int lat;
        int s0;
        int errs;
        int bp_errs;

        rst = 1'b1; araddr = 32'd0; arvalid = 1'b0; rready = 1'b1;
        store_done = 1'b0; img_reg = 2'b10; int_reg = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_arready", {31'd0, arready}, 32'd1);
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_strobe", {31'd0, read_result_mem}, 32'd0);
        chk("reset_addr", {16'd0, result_mem_addr}, 32'd0);
        chk("reset_done", {31'd0, read_done}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Status registers
        rd(IMG_A, d, lat);
        chk("img_data", d, 32'h0000_0002);
        chk("img_lat", 32'(lat), 32'd0);
        rd(INT_A, d, lat);
        chk("int_data", d, 32'h0000_0001);
        img_reg = 2'b01; int_reg = 1'b0;
        rd(IMG_A, d, lat);
        chk("img_data2", d, 32'h0000_0001);
        rd(INT_A, d, lat);
        chk("int_data0", d, 32'h0000_0000);
        chk("arready_after_resp", {31'd0, arready}, 32'd1);

        // Result window before the store completes
        s0 = strobe_cnt;
        rd(RES_A, d, lat);
        chk("notready_data", d, 32'd0);
        chk("notready_lat", 32'(lat), 32'd0);
        chk("notready_strobes", 32'(strobe_cnt - s0), 32'd0);

        // Full sweep of the result memory
        store_done = 1'b1;
        s0 = strobe_cnt;
        errs = 0;
        for (int i = 0; i < 8192; i++) begin
            rd(RES_A, d, lat);
            v = 16'(i - 4096);
            if (i == 0) chk("seq_first_data", d, 32'hFFFF_F000);
            if (i == 8191) chk("seq_last_data", d, 32'h0000_0FFF);
            if (d !== {{16{v[15]}}, v} || last_addr !== 16'(i) || lat != 1) errs++;
        end
        chk("seq_errors", 32'(errs), 32'd0);
        chk("seq_strobes", 32'(strobe_cnt - s0), 32'd8192);
        chk("seq_done_pulses", 32'(done_cnt), 32'd1);
        rd(RES_A, d, lat);
        chk("wrap_addr", {16'd0, last_addr}, 32'd0);
        chk("wrap_data", d, 32'hFFFF_F000);
        chk("wrap_done_pulses", 32'(done_cnt), 32'd1);

        // Backpressure during a result response
        rready = 1'b0;
        s0 = strobe_cnt;
        @(negedge clk);
        araddr = RES_A; arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(posedge clk);
        #1 d0 = rdata;
        bp_errs = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) bp_errs++;
        end
        chk("bp_hold", 32'(bp_errs), 32'd0);
        chk("bp_data", d0, 32'hFFFF_F001);
        chk("bp_strobes", 32'(strobe_cnt - s0), 32'd1);
        rready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_exit_arready", {31'd0, arready}, 32'd1);
        chk("bp_exit_rvalid", {31'd0, rvalid}, 32'd0);

        // Unmapped address
        s0 = strobe_cnt;
        rd(32'hd000_0004, d, lat);
        chk("unmapped_data", d, 32'd0);
        chk("unmapped_strobes", 32'(strobe_cnt - s0), 32'd0);
        rd(RES_A, d, lat);
        chk("after_unmapped_addr", {16'd0, last_addr}, 32'd2);
        chk("after_unmapped_data", d, 32'hFFFF_F002);

        // store_done dropping keeps the counter
        store_done = 1'b0;
        rd(RES_A, d, lat);
        chk("drop_data", d, 32'd0);
        store_done = 1'b1;
        rd(RES_A, d, lat);
        chk("drop_resume_addr", {16'd0, last_addr}, 32'd3);

        // Reset asserted mid-response
        rready = 1'b0;
        @(negedge clk);
        araddr = IMG_A; arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk) rst = 1'b0;
        rready = 1'b1;
        rd(RES_A, d, lat);
        chk("rst_count_addr", {16'd0, last_addr}, 32'd0);
        chk("rst_count_data", d, 32'hFFFF_F000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
